e_mdu: RTL and testbench
========================

# e_mdu

Execute-stage multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the D→E pipeline register and consumes the E-stage operands (v1_e/v2_e after forwarding) and the decoded md-class operation. It runs multi-cycle MULT/DIV operations, exposes `busy` to the hazard unit and serves MFHI/MFLO reads. The hazard unit stalls D while `busy|start` is high and D holds an md-class instruction.

## Interface
- MULT_CYCLES, 5, cycles `busy` stays high for MULT/MULTU (and MADD family); ≥1
- DIV_CYCLES, 10, cycles `busy` stays high for DIV/DIVU; ≥1
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  E-stage instruction is md-class; qualifies `op`
- kill  in  1  exception/interrupt taken on the E-stage instruction this cycle; suppresses `start`
- op  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU, other = no-op
- a  in  32  rs operand (forwarded v1_e)
- b  in  32  rt operand (forwarded v2_e)
- hi_sel  in  1  1 = `rdata` returns HI, 0 = LO
- rdata  out  32  committed HI or LO, combinational from the registers
- busy  out  1  multi-cycle operation in progress

## Operation
- State: IDLE, RUN. Registers: hi, lo, pend_hi, pend_lo, cnt (4 bits min, sized to max(MULT_CYCLES, DIV_CYCLES)), `busy`.
- Effective start = `start & ~kill & ~busy`. `start` while `busy` is ignored entirely, including MTHI/MTLO. The hazard unit guarantees this never occurs legally.
- IDLE + effective MULT/MULTU: pend = full 64-bit product, signed or unsigned respectively; cnt ← MULT_CYCLES; → RUN.
- IDLE + effective DIV/DIVU: pend_lo = quotient, pend_hi = remainder.
  - DIV truncates toward zero; remainder takes the sign of the dividend.
  - cnt ← DIV_CYCLES; → RUN.
- Divide by zero (b == 0): enters RUN for DIV_CYCLES as normal, but HI/LO are left unchanged at completion.
- MADD/MADDU/MSUB/MSUBU: pend = {hi,lo} ± product (64-bit, wraps modulo 2^64); cnt ← MULT_CYCLES; → RUN. These exist only with the macro; see Configuration.
- MTHI/MTLO (effective): hi or lo ← a at the next edge; no RUN, `busy` stays 0.
- RUN: cnt decrements each edge. On the edge where cnt == 1, {hi,lo} ← pend (unless divide-by-zero), `busy` ← 0, → IDLE.
- `kill` does not abort an operation already in RUN. Only a same-cycle start is suppressed.
- Operands are sampled only at the start edge. Later changes on `a`/`b` have no effect.
- `rdata` always reflects committed hi/lo. Pending results are never visible.

## Timing
- Reset (async, reset_n = 0): hi = lo = 0, pend = 0, cnt = 0, `busy` = 0, state IDLE. `rdata` = 0.
- Reset asserted mid-RUN: the operation is discarded immediately; hi/lo return to 0.
- Start accepted at edge T:
  - `busy` = 1 after T;
  - `busy` falls after edge T + N, where N = MULT_CYCLES or DIV_CYCLES;
  - `busy` is high for exactly N cycles.
- The new HI/LO value is readable on `rdata` in the cycle after `busy` falls (edge T+N).
- Back-to-back: a start presented in the first cycle with `busy` = 0 is accepted. There is no idle gap.
- MTHI/MTLO at edge T: visible on `rdata` after T.

## Configuration
- `MDU_MADD_EN` defined: op 6–9 implemented as above.
- Without `MDU_MADD_EN`: op 6–9 are no-ops. HI/LO are unchanged, `busy` stays 0, and no accumulate datapath is synthesized.

## Test plan
- Reset → `rdata` = 0 for both values of `hi_sel`; `busy` = 0. Assert reset_n low mid-DIV → `busy` = 0 and HI = LO = 0 asynchronously.
- MULT a=0xFFFFFFFD, b=7 → `busy` high exactly 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. MULTU with the same operands → HI = 0x00000006, LO = 0xFFFFFFEB.
- DIVU 100/7 → `busy` high 10 cycles, LO = 14, HI = 2. DIV −7/2 (0xFFFFFFF9, 2) → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- MTHI 0x12345678, then DIV 5/0 → `busy` high 10 cycles, HI still 0x12345678, LO unchanged.
- MULT with `kill` = 1 → `busy` stays 0, HI/LO unchanged. DIV started, then a MULT start during RUN with `kill` toggling → the DIV completes at T+10 and the MULT is ignored.
- With `MDU_MADD_EN`: HI:LO = 0:10, then MADD 3×4 → LO = 22 after 5 cycles; MSUBU 0×0 → unchanged. Without the macro: MADD → `busy` 0, LO stays 10.

Source files
------------

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - execute-stage multiply/divide unit with architectural HI/LO registers
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only when MDU_MADD_EN is defined.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        kill,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_sel,
  output logic [31:0] rdata,
  output logic        busy
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             state, state_n;
  logic [31:0]        hi, lo, pend_hi, pend_lo;
  logic [31:0]        hi_n, lo_n, pend_hi_n, pend_lo_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               busy_n;
  logic               pend_div0, pend_div0_n;
  logic               go, mul_launch, div_launch;

  logic [63:0]        prod_s, prod_u;
  logic [31:0]        div_b, q_s, r_s, q_u, r_u;
  logic               div0;

  assign go = start & ~kill & ~busy;

  assign prod_s = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
  assign prod_u = {32'd0, a} * {32'd0, b};

  // A zero divisor is swapped for 1 so the dividers stay defined; the result is discarded anyway.
  assign div0  = (b == 32'd0);
  assign div_b = div0 ? 32'd1 : b;
  assign q_s   = 32'($signed(a) / $signed(div_b));
  assign r_s   = 32'($signed(a) % $signed(div_b));
  assign q_u   = a / div_b;
  assign r_u   = a % div_b;

  assign rdata = hi_sel ? hi : lo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      hi        <= 32'd0;
      lo        <= 32'd0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      cnt       <= '0;
      busy      <= 1'b0;
      pend_div0 <= 1'b0;
    end else begin
      state     <= state_n;
      hi        <= hi_n;
      lo        <= lo_n;
      pend_hi   <= pend_hi_n;
      pend_lo   <= pend_lo_n;
      cnt       <= cnt_n;
      busy      <= busy_n;
      pend_div0 <= pend_div0_n;
    end
  end

  always_comb begin
    state_n     = state;
    hi_n        = hi;
    lo_n        = lo;
    pend_hi_n   = pend_hi;
    pend_lo_n   = pend_lo;
    cnt_n       = cnt;
    busy_n      = busy;
    pend_div0_n = pend_div0;
    mul_launch  = 1'b0;
    div_launch  = 1'b0;

    case (state)
      S_IDLE: begin
        if (go) begin
          case (op)
            OP_MULT:  begin {pend_hi_n, pend_lo_n} = prod_s; mul_launch = 1'b1; end
            OP_MULTU: begin {pend_hi_n, pend_lo_n} = prod_u; mul_launch = 1'b1; end
            OP_DIV:   begin pend_hi_n = r_s; pend_lo_n = q_s; div_launch = 1'b1; end
            OP_DIVU:  begin pend_hi_n = r_u; pend_lo_n = q_u; div_launch = 1'b1; end
            OP_MTHI:  hi_n = a;
            OP_MTLO:  lo_n = a;
`ifdef MDU_MADD_EN
            OP_MADD:  begin {pend_hi_n, pend_lo_n} = {hi, lo} + prod_s; mul_launch = 1'b1; end
            OP_MADDU: begin {pend_hi_n, pend_lo_n} = {hi, lo} + prod_u; mul_launch = 1'b1; end
            OP_MSUB:  begin {pend_hi_n, pend_lo_n} = {hi, lo} - prod_s; mul_launch = 1'b1; end
            OP_MSUBU: begin {pend_hi_n, pend_lo_n} = {hi, lo} - prod_u; mul_launch = 1'b1; end
`endif
            default: ;
          endcase
          if (mul_launch) begin
            cnt_n       = CNT_W'(MULT_CYCLES);
            pend_div0_n = 1'b0;
            busy_n      = 1'b1;
            state_n     = S_RUN;
          end
          if (div_launch) begin
            cnt_n       = CNT_W'(DIV_CYCLES);
            pend_div0_n = div0;
            busy_n      = 1'b1;
            state_n     = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          if (!pend_div0) begin
            hi_n = pend_hi;
            lo_n = pend_lo;
          end
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - scoreboard testbench for e_mdu
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        kill;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_sel;
  logic [31:0] rdata;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .kill(kill), .op(op),
    .a(a), .b(b), .hi_sel(hi_sel), .rdata(rdata), .busy(busy)
  );

  // Present one start at the current negedge; operands are scrambled right after acceptance.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic k);
    start = 1'b1; op = o; a = x; b = y; kill = k;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input int n_exp, input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== n_exp) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, n_exp);
    end
  endtask

  task automatic check_regs(input string name);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard: queue empty got 0 entries expected 1", name);
      return;
    end
    e = exp_q.pop_front();
    checks += 2;
    hi_sel = 1'b1; #1;
    if (rdata !== e[63:32]) begin
      failures++;
      $display("FAIL %s hi: got %08h expected %08h", name, rdata, e[63:32]);
    end
    hi_sel = 1'b0; #1;
    if (rdata !== e[31:0]) begin
      failures++;
      $display("FAIL %s lo: got %08h expected %08h", name, rdata, e[31:0]);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy: got %b expected 0", name, busy);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; kill = 1'b0; op = 4'd0; a = '0; b = '0; hi_sel = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    exp_q.push_back(64'd0);
    check_regs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_mult;
    issue(4'd0, 32'hFFFFFFFD, 32'd7, 1'b0);
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
    wait_done(5, "mult");
    check_regs("mult");
    issue(4'd1, 32'hFFFFFFFD, 32'd7, 1'b0);
    exp_q.push_back({32'h00000006, 32'hFFFFFFEB});
    wait_done(5, "multu");
    check_regs("multu");
  endtask

  task automatic test_div;
    issue(4'd3, 32'd100, 32'd7, 1'b0);
    exp_q.push_back({32'd2, 32'd14});
    wait_done(10, "divu");
    check_regs("divu");
    issue(4'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    wait_done(10, "div_neg");
    check_regs("div_neg");
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFD;
  endtask

  task automatic test_div0;
    issue(4'd4, 32'h12345678, 32'd0, 1'b0);
    check_idle("mthi");
    m_hi = 32'h12345678;
    exp_q.push_back({m_hi, m_lo});
    check_regs("mthi");
    @(negedge clk);
    issue(4'd2, 32'd5, 32'd0, 1'b0);
    exp_q.push_back({m_hi, m_lo});
    wait_done(10, "div0");
    check_regs("div0");
  endtask

  task automatic test_kill;
    int n = 0;
    @(negedge clk);
    issue(4'd0, 32'd9, 32'd9, 1'b1);
    check_idle("kill_start");
    repeat (3) @(negedge clk);
    check_idle("kill_later");
    exp_q.push_back({m_hi, m_lo});
    check_regs("kill");
    // A MULT start with kill toggling while the DIV runs must be ignored.
    @(negedge clk);
    issue(4'd3, 32'd50, 32'd6, 1'b0);
    exp_q.push_back({32'd2, 32'd8});
    @(negedge clk);
    while (busy && n < 100) begin
      if (n < 6) begin start = 1'b1; op = 4'd0; a = 32'd3; b = 32'd3; kill = n[0]; end
      else begin start = 1'b0; kill = 1'b0; end
      n++;
      @(negedge clk);
    end
    start = 1'b0; kill = 1'b0;
    checks++;
    if (n !== 10) begin
      failures++;
      $display("FAIL kill_run busy_cycles: got %0d expected 10", n);
    end
    check_regs("kill_run");
    m_hi = 32'd2; m_lo = 32'd8;
  endtask

  task automatic test_back_to_back;
    logic [31:0] x, y;
    logic [63:0] p;
    for (int i = 0; i < 6; i++) begin
      x = $urandom; y = $urandom_range(1, 1000);
      if (i[0]) begin
        issue(4'd3, x, y, 1'b0);
        exp_q.push_back({x % y, x / y});
        wait_done(10, "b2b_divu");
      end else begin
        p = {32'd0, x} * {32'd0, y};
        issue(4'd1, x, y, 1'b0);
        exp_q.push_back(p);
        wait_done(5, "b2b_multu");
      end
      check_regs("b2b");
    end
  endtask

  task automatic test_madd;
    issue(4'd4, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    issue(4'd5, 32'd10, 32'd0, 1'b0);
    exp_q.push_back({32'd0, 32'd10});
    check_regs("madd_setup");
    @(negedge clk);
`ifdef MDU_MADD_EN
    issue(4'd6, 32'd3, 32'd4, 1'b0);
    exp_q.push_back({32'd0, 32'd22});
    wait_done(5, "madd");
    check_regs("madd");
    issue(4'd9, 32'd0, 32'd0, 1'b0);
    exp_q.push_back({32'd0, 32'd22});
    wait_done(5, "msubu");
    check_regs("msubu");
`else
    issue(4'd6, 32'd3, 32'd4, 1'b0);
    check_idle("madd_noop");
    repeat (6) @(negedge clk);
    check_idle("madd_noop_later");
    exp_q.push_back({32'd0, 32'd10});
    check_regs("madd_noop");
`endif
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    issue(4'd3, 32'd1000, 32'd3, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_idle("reset_mid");
    exp_q.push_back(64'd0);
    check_regs("reset_mid");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check_idle("reset_mid_after");
    exp_q.push_back(64'd0);
    check_regs("reset_mid_after");
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div0;
    test_kill;
    test_back_to_back;
    test_madd;
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
